// File: rtl/pipe_out_block_arbiter.sv
// Round-robin block arbiter: grants one full BLOCK_WORDS block at a time from
// N_SRC FWFT source FIFOs to a single block-throttled pipe-out endpoint.
module pipe_out_block_arbiter #(
  parameter int N_SRC       = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 16,
  parameter int ID_W        = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [N_SRC*CNT_W-1:0] i_src_count,
  input  logic [N_SRC*32-1:0]    i_src_data,
  output logic [N_SRC-1:0]       o_src_rd,
  input  logic [N_SRC-1:0]       i_enable_mask,
  input  logic                   i_halt,
  input  logic                   i_pipe_out_read,
  output logic                   o_pipe_out_ready,
  output logic [31:0]            o_pipe_out_data,
  output logic [ID_W-1:0]        o_grant_id,
  output logic                   o_busy,
  output logic [31:0]            o_blocks_sent,
  output logic [15:0]            o_overrun_errors
);

  localparam int WC_W = $clog2(BLOCK_WORDS + 1);
  localparam logic [CNT_W-1:0] BLK_CNT   = CNT_W'(BLOCK_WORDS);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_READY = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_last_grant;
  logic [WC_W-1:0]   r_word_cnt;
  logic [31:0]       r_blocks_sent;
  logic [15:0]       r_overrun_errors;

  logic [N_SRC-1:0]  w_elig;
  logic              w_found;
  logic [ID_W-1:0]   w_pick;
  logic              w_grant_load;
  logic              w_block_done;
  logic              w_active;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_elig
      assign w_elig[gi] = i_enable_mask[gi] && (i_src_count[gi*CNT_W +: CNT_W] >= BLK_CNT);
    end
  endgenerate

  // Search last_grant+1, +2, ... so the previous winner is considered last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (!w_found && (j == ((int'(r_last_grant) + k) % N_SRC)) && w_elig[j]) begin
          w_found = 1'b1;
          w_pick  = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_load = 1'b0;
    w_block_done = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (!i_halt && w_found) begin
          w_state_next = ST_READY;
          w_grant_load = 1'b1;
        end
      end
      ST_READY: begin
        if (i_pipe_out_read) begin
          if (BLOCK_WORDS == 1) begin
            w_block_done = 1'b1;
            w_state_next = ST_ARB;
          end else begin
            w_state_next = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (i_pipe_out_read && (r_word_cnt == LAST_WORD)) begin
          w_block_done = 1'b1;
          w_state_next = ST_ARB;
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= ST_ARB;
      r_grant_id       <= '0;
      r_last_grant     <= ID_W'(N_SRC - 1);
      r_word_cnt       <= '0;
      r_blocks_sent    <= '0;
      r_overrun_errors <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_load) begin
        r_grant_id <= w_pick;
      end
      if (w_block_done) begin
        r_word_cnt    <= '0;
        r_blocks_sent <= r_blocks_sent + 32'd1;
        r_last_grant  <= r_grant_id;
      end else if (r_state == ST_READY && i_pipe_out_read) begin
        r_word_cnt <= WC_W'(1);
      end else if (r_state == ST_BURST && i_pipe_out_read) begin
        r_word_cnt <= r_word_cnt + WC_W'(1);
      end
      if (r_state == ST_ARB && i_pipe_out_read && r_overrun_errors != 16'hFFFF) begin
        r_overrun_errors <= r_overrun_errors + 16'd1;
      end
    end
  end

  assign w_active = (r_state == ST_READY) || (r_state == ST_BURST);

  always_comb begin
    o_src_rd        = '0;
    o_pipe_out_data = 32'h0;
    for (int j = 0; j < N_SRC; j++) begin
      if (w_active && (ID_W'(j) == r_grant_id)) begin
        o_src_rd[j]     = i_pipe_out_read;
        o_pipe_out_data = i_src_data[j*32 +: 32];
      end
    end
  end

  assign o_pipe_out_ready = (r_state == ST_READY);
  assign o_busy           = w_active;
  assign o_grant_id       = r_grant_id;
  assign o_blocks_sent    = r_blocks_sent;
  assign o_overrun_errors = r_overrun_errors;

endmodule

// File: doc/pipe_out_block_arbiter.md
Name: pipe_out_block_arbiter

Overview:
Shares one block-throttled pipe-out endpoint among N_SRC first-word-fall-through source FIFOs. Each source is granted one whole block of BLOCK_WORDS words, in round-robin order, and only once it holds a full block. The block sits between the per-channel capture FIFOs and the pipe-out endpoint on okClk. It drives the endpoint ready, the read-strobe fan-out and the data mux, and exports status for wire-outs.

Parameters:
N_SRC, 4, number of source FIFOs (2..8)
BLOCK_WORDS, 256, 32-bit words per block; must match the host block size
CNT_W, 16, width of each source fill-level input
ID_W, 2, width of grant index, ceil(log2(N_SRC))

Ports:
clk  in  1  okClk, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
src_count  in  N_SRC*CNT_W  per-source FIFO fill level in words
src_data  in  N_SRC*32  per-source FWFT head word
src_rd  out  N_SRC  per-source read strobe (one-hot or zero)
enable_mask  in  N_SRC  per-source enable, from wire-in
halt  in  1  finish current block, then stop granting
pipe_out_read  in  1  endpoint read strobe
pipe_out_ready  out  1  endpoint block-ready
pipe_out_data  out  32  endpoint data
grant_id  out  ID_W  index of the current or last granted source
busy  out  1  high in READY or BURST
blocks_sent  out  32  completed blocks, wraps at 2^32
overrun_errors  out  16  reads outside a grant, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync release) values:
  - state=ARB, pipe_out_ready=0, src_rd=0, grant_id=0, last_grant=N_SRC-1, word_cnt=0, blocks_sent=0, overrun_errors=0.
  - Reset mid-burst abandons the block; the partial block is not counted.
- Eligibility: source i is eligible when enable_mask[i]=1 and src_count[i] >= BLOCK_WORDS (unsigned compare, CNT_W bits).
- ARB:
  - If halt=1 or no source is eligible, stay in ARB; ready=0.
  - Otherwise pick the first eligible index searching last_grant+1, +2, ... mod N_SRC.
  - Register grant_id, then go to READY. pipe_out_ready rises the next cycle, so latency is 1 cycle from ARB evaluation.
- READY:
  - pipe_out_ready=1.
  - On pipe_out_read=1, go to BURST; ready drops the same edge.
  - The first read counts as word 1.
- BURST:
  - ready=0.
  - Each read increments word_cnt.
  - When the read making word_cnt==BLOCK_WORDS occurs:
    - word_cnt is cleared;
    - blocks_sent increments;
    - last_grant is set to grant_id;
    - the state goes to ARB.
  - There is at least 1 idle ARB cycle between blocks.
- Datapath (combinational):
  - src_rd[grant_id] = pipe_out_read while state is READY or BURST; all other src_rd bits are 0.
  - pipe_out_data = src_data[grant_id] in READY/BURST, else 32'h0.
- Reads outside a grant: pipe_out_read in ARB increments overrun_errors, saturating. No src_rd is issued.
- Changes to enable_mask and halt:
  - Both are sampled only in ARB.
  - Deasserting a bit, or asserting halt, during READY/BURST does not cut the current block.
  - halt asserted in READY with no read yet still honours the pending grant.
- Simultaneous eligibility: strictly round-robin. No source gets two consecutive blocks while another is eligible.
- A single eligible source may be granted back-to-back.
- busy = (state==READY or BURST).
- grant_id holds its last value while in ARB.

Test Plan:
- Reset, then src_count={0,0,0,300}, mask=4'hF -> ready rises 2 cycles after reset release; grant_id=3; 256 reads assert src_rd=4'b1000 256 times; blocks_sent=1.
- All four counts=512, mask=4'hF, host reads 8 blocks -> grant order 0,1,2,3,0,1,2,3; blocks_sent=8; pipe_out_data matches each source's sequence.
- Count 255 on source 0 only -> ready stays 0; raise count to 256 -> ready=1 after 1 ARB cycle.
- mask=4'b0101, all counts full -> grants alternate 0,2,0,2. Clearing mask bit 2 mid-burst of source 2 completes that block, then only 0 is granted.
- Assert halt at word 100 of a block -> remaining 156 words are delivered; then ready stays 0 and busy=0; deasserting halt resumes with the next RR source.
- 3 reads issued in ARB -> overrun_errors=3, src_rd stays 0. Separately, reset_n pulsed at word 50 -> all outputs go to reset values immediately and blocks_sent=0.
